// File: rtl/if_id_queue_pkg.sv
// Shared constants for the IF->ID queue and the fetch/control logic that sizes it.
package if_id_queue_pkg;

  localparam logic        RstEnable  = 1'b1;
  localparam logic        ChipEnable = 1'b1;
  localparam logic [31:0] ZeroWord   = 32'h0000_0000;

  // Default queue depth; ctrl and pc_reg size their logic from this value too.
  localparam int          IfIdDepth  = 2;

endpackage

// File: rtl/if_id_ram.sv
// DEPTH x W register array for the IF->ID queue: one write port, one asynchronous read port.
module if_id_ram
  import if_id_queue_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 2,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [W-1:0]     wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [W-1:0]     rdata_o
);

  // Storage is intentionally not reset; the queue masks unoccupied entries.
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i == ChipEnable) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_queue.sv
// IF->ID pipeline stage: DEPTH-entry first-word-fall-through queue with valid/ready
// handshake on both sides, decode stall and flush.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = IfIdDepth
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       if_valid,
  output logic                       if_ready,
  input  logic [ADDR_W-1:0]          if_pc,
  input  logic [INST_W-1:0]          if_inst,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [ADDR_W-1:0]          id_pc,
  output logic [INST_W-1:0]          id_inst,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = ADDR_W + INST_W;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic             empty, full, push, pop;
  logic [ENT_W-1:0] head;

  // Extra wrap bit distinguishes full from empty when the indices coincide.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                 (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);

  assign if_ready = ~full;
  assign id_valid = ~empty;
  assign push     = if_valid & if_ready;
  assign pop      = id_valid & id_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  if_id_ram #(
    .W     (ENT_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (push & ~flush),
    .waddr_i (wr_ptr_q[IDX_W-1:0]),
    .wdata_i ({if_pc, if_inst}),
    .raddr_i (rd_ptr_q[IDX_W-1:0]),
    .rdata_o (head)
  );

  // Empty queue presents a NOP bubble instead of whatever the head slot holds.
  assign id_pc   = id_valid ? head[ENT_W-1:INST_W] : '0;
  assign id_inst = id_valid ? head[INST_W-1:0]     : '0;
  assign count   = count_q;

endmodule
